mem_arbiter: RTL and testbench

- Two-port arbiter that shares the single-port 512x12 Simplez main memory between two requesters.
  - Port A: the CPU.
  - Port B: the serial program loader / debug port.
- Sits between the requesters and the memory. Drives the memory's addr/wr/data_in and returns its data_out.
- The memory is accessed on the falling clock edge. This block works on the rising edge, so each access occupies exactly one ACCESS cycle.
- Requesters use a req/ack handshake. Contention is resolved by round-robin or fixed priority.

---
 rtl/mem_arbiter_if.sv | 29 ++
 rtl/mem_arbiter.sv | 114 +++++++++++
 tb/tb_mem_arbiter.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Requester-side bus of the memory arbiter: one instance per port.
//   req   - request, held until ack is seen
//   wr    - 1 = write, 0 = read; stable while req is high
//   addr  - word address
//   wdata - write data
//   ack   - one-cycle completion pulse
//   rdata - read data, valid with ack and held until the next read completes
// master: the requester (CPU or loader); slave: the arbiter.
interface mem_arbiter_if #(
  parameter int AW = 9,
  parameter int DW = 12
);
  logic          req;
  logic          wr;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          ack;
  logic [DW-1:0] rdata;

  modport master (
    output req, wr, addr, wdata,
    input  ack, rdata
  );

  modport slave (
    input  req, wr, addr, wdata,
    output ack, rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port arbiter for the single-port 512x12 Simplez main memory.
// Port A is the CPU, port B the serial loader / debug port.
// The memory acts on the falling edge, so each access owns exactly one
// ACCESS cycle of this rising-edge controller.
//   clk, rst   - clock; synchronous active-high reset
//   port_a/b   - requester handshake buses (mem_arbiter_if.slave)
//   mem_addr   - memory address, holds its last value outside ACCESS
//   mem_wr     - memory write strobe, high only in ACCESS
//   mem_wdata  - memory write data, holds its last value outside ACCESS
//   mem_rdata  - memory read data, updated on the falling edge
//   busy       - high in ACCESS and DONE
//   grant      - last/current winner: 0 = A, 1 = B
//
// state  | meaning
// IDLE   | sample req_a/req_b, pick a winner, latch its address/data/wr
// ACCESS | memory strobes stable; memory acts at the mid-cycle falling edge
// DONE   | winner's ack high; requests ignored for this cycle
module mem_arbiter #(
  parameter int AW          = 9,
  parameter int DW          = 12,
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  port_a,
  mem_arbiter_if.slave  port_b,
  output logic [AW-1:0] mem_addr,
  output logic          mem_wr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          grant
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t        state;
  logic          ack_a;
  logic          ack_b;
  logic [DW-1:0] rdata_a;
  logic [DW-1:0] rdata_b;
  logic          pick_b;

  assign port_a.ack   = ack_a;
  assign port_a.rdata = rdata_a;
  assign port_b.ack   = ack_b;
  assign port_b.rdata = rdata_b;

  // On a tie, round-robin hands the slot to whoever did not win last;
  // grant resets to 1 so A takes the first tie.
  always_comb begin
    pick_b = 1'b0;
    if (port_a.req && port_b.req) begin
      pick_b = ROUND_ROBIN ? ~grant : 1'b0;
    end else begin
      pick_b = port_b.req;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ack_a     <= 1'b0;
      ack_b     <= 1'b0;
      mem_wr    <= 1'b0;
      busy      <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata_a   <= '0;
      rdata_b   <= '0;
      grant     <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (port_a.req || port_b.req) begin
            grant     <= pick_b;
            mem_addr  <= pick_b ? port_b.addr  : port_a.addr;
            mem_wdata <= pick_b ? port_b.wdata : port_a.wdata;
            mem_wr    <= pick_b ? port_b.wr    : port_a.wr;
            busy      <= 1'b1;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          // mem_wr still reflects the access just performed, so it selects
          // whether the returned word is captured.
          mem_wr <= 1'b0;
          if (grant) begin
            ack_b <= 1'b1;
            if (!mem_wr) rdata_b <= mem_rdata;
          end else begin
            ack_a <= 1'b1;
            if (!mem_wr) rdata_a <= mem_rdata;
          end
          state <= DONE;
        end
        DONE: begin
          ack_a <= 1'b0;
          ack_b <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          ack_a  <= 1'b0;
          ack_b  <= 1'b0;
          mem_wr <= 1'b0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one round-robin instance and one
// fixed-priority instance, each with its own falling-edge memory model.
module tb_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst1;

  mem_arbiter_if #(.AW(9), .DW(12)) pa0 ();
  mem_arbiter_if #(.AW(9), .DW(12)) pb0 ();
  mem_arbiter_if #(.AW(9), .DW(12)) pa1 ();
  mem_arbiter_if #(.AW(9), .DW(12)) pb1 ();

  logic [8:0]  mem_addr0, mem_addr1;
  logic        mem_wr0, mem_wr1;
  logic [11:0] mem_wdata0, mem_wdata1;
  logic [11:0] mem_rdata0, mem_rdata1;
  logic        busy0, busy1, grant0, grant1;

  mem_arbiter #(.AW(9), .DW(12), .ROUND_ROBIN(1'b1)) u_dut0 (
    .clk(clk), .rst(rst0), .port_a(pa0), .port_b(pb0),
    .mem_addr(mem_addr0), .mem_wr(mem_wr0), .mem_wdata(mem_wdata0),
    .mem_rdata(mem_rdata0), .busy(busy0), .grant(grant0)
  );

  mem_arbiter #(.AW(9), .DW(12), .ROUND_ROBIN(1'b0)) u_dut1 (
    .clk(clk), .rst(rst1), .port_a(pa1), .port_b(pb1),
    .mem_addr(mem_addr1), .mem_wr(mem_wr1), .mem_wdata(mem_wdata1),
    .mem_rdata(mem_rdata1), .busy(busy1), .grant(grant1)
  );

  // Memory models: act on the falling edge, with a backdoor preload port.
  logic [11:0] mem0 [512];
  logic [11:0] mem1 [512];
  logic        bd_we0 = 1'b0, bd_we1 = 1'b0;
  logic [8:0]  bd_addr = '0;
  logic [11:0] bd_data = '0;

  always @(negedge clk) begin
    if (bd_we0) mem0[bd_addr] <= bd_data;
    else if (mem_wr0) mem0[mem_addr0] <= mem_wdata0;
    mem_rdata0 <= mem_wr0 ? mem_wdata0 : mem0[mem_addr0];
  end

  always @(negedge clk) begin
    if (bd_we1) mem1[bd_addr] <= bd_data;
    else if (mem_wr1) mem1[mem_addr1] <= mem_wdata1;
    mem_rdata1 <= mem_wr1 ? mem_wdata1 : mem1[mem_addr1];
  end

  // Cycle monitors on instance 0.
  int cyc0 = 0, wr_cyc0 = 0, ackb_cnt0 = 0, both_ack = 0;
  always @(posedge clk) begin
    cyc0++;
    if (mem_wr0) wr_cyc0++;
    if (pb0.ack) ackb_cnt0++;
    if ((pa0.ack && pb0.ack) || (pa1.ack && pb1.ack)) both_ack++;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0o expected %0o", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input bit which, input logic [8:0] a, input logic [11:0] d);
    bd_addr = a;
    bd_data = d;
    if (which) bd_we1 = 1'b1; else bd_we0 = 1'b1;
    @(negedge clk);
    #1;
    bd_we0 = 1'b0;
    bd_we1 = 1'b0;
  endtask

  task automatic check_reset0(input string tag);
    check({tag, "_ack_a"},     32'(pa0.ack),    32'd0);
    check({tag, "_ack_b"},     32'(pb0.ack),    32'd0);
    check({tag, "_mem_wr"},    32'(mem_wr0),    32'd0);
    check({tag, "_busy"},      32'(busy0),      32'd0);
    check({tag, "_mem_addr"},  32'(mem_addr0),  32'd0);
    check({tag, "_mem_wdata"}, 32'(mem_wdata0), 32'd0);
    check({tag, "_rdata_a"},   32'(pa0.rdata),  32'd0);
    check({tag, "_rdata_b"},   32'(pb0.rdata),  32'd0);
    check({tag, "_grant"},     32'(grant0),     32'd1);
  endtask

  // Single-port transaction on instance 0; returns cycles from request to ack
  // (-1 on timeout) and the memory strobes seen in the first cycle.
  task automatic txn0(input bit sel_b, input bit w, input logic [8:0] a,
                      input logic [11:0] d, output int lat,
                      output logic [8:0] acc_addr, output logic acc_wr);
    if (sel_b) begin
      pb0.req = 1'b1; pb0.wr = w; pb0.addr = a; pb0.wdata = d;
    end else begin
      pa0.req = 1'b1; pa0.wr = w; pa0.addr = a; pa0.wdata = d;
    end
    lat = -1;
    acc_addr = '0;
    acc_wr = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i == 1) begin
        acc_addr = mem_addr0;
        acc_wr = mem_wr0;
      end
      if ((sel_b ? pb0.ack : pa0.ack) === 1'b1) begin
        lat = i;
        break;
      end
    end
    pa0.req = 1'b0;
    pb0.req = 1'b0;
    tick();
  endtask

  int          lat, w0, ab0, na, nb, got;
  int          t [3];
  logic [11:0] rd [3];
  logic [8:0]  acc_addr;
  logic        acc_wr;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    pa0.req = 0; pa0.wr = 0; pa0.addr = '0; pa0.wdata = '0;
    pb0.req = 0; pb0.wr = 0; pb0.addr = '0; pb0.wdata = '0;
    pa1.req = 0; pa1.wr = 0; pa1.addr = '0; pa1.wdata = '0;
    pb1.req = 0; pb1.wr = 0; pb1.addr = '0; pb1.wdata = '0;
    rst0 = 1'b1;
    rst1 = 1'b1;
    tick();
    tick();
    rst0 = 1'b0;
    rst1 = 1'b0;
    check_reset0("rst");

    // A reads addr 0
    poke(0, 9'd0, 12'o1006);
    w0 = wr_cyc0;
    txn0(0, 0, 9'd0, 12'o0, lat, acc_addr, acc_wr);
    check("rd0_latency", 32'(lat), 32'd2);
    check("rd0_addr", 32'(acc_addr), 32'd0);
    check("rd0_rdata_a", 32'(pa0.rdata), 32'o1006);
    check("rd0_no_wr", 32'(wr_cyc0 - w0), 32'd0);
    check("rd0_rdata_b", 32'(pb0.rdata), 32'd0);
    check("rd0_ack_cleared", 32'(pa0.ack), 32'd0);
    check("rd0_grant", 32'(grant0), 32'd0);

    // B writes o7000 to addr 3, then A reads it back
    w0 = wr_cyc0;
    txn0(1, 1, 9'd3, 12'o7000, lat, acc_addr, acc_wr);
    check("wr3_latency", 32'(lat), 32'd2);
    check("wr3_addr", 32'(acc_addr), 32'd3);
    check("wr3_wr", 32'(acc_wr), 32'd1);
    check("wr3_wr_cycles", 32'(wr_cyc0 - w0), 32'd1);
    check("wr3_mem", 32'(mem0[3]), 32'o7000);
    check("wr3_rdata_b", 32'(pb0.rdata), 32'd0);
    check("wr3_grant", 32'(grant0), 32'd1);
    txn0(0, 0, 9'd3, 12'o0, lat, acc_addr, acc_wr);
    check("rd3_latency", 32'(lat), 32'd2);
    check("rd3_rdata_a", 32'(pa0.rdata), 32'o7000);

    // Round-robin contention right after reset
    rst0 = 1'b1;
    tick();
    rst0 = 1'b0;
    poke(0, 9'd6, 12'o0003);
    poke(0, 9'd7, 12'o0001);
    pa0.req = 1; pa0.wr = 0; pa0.addr = 9'd6;
    pb0.req = 1; pb0.wr = 0; pb0.addr = 9'd7;
    tick();
    check("rr1_grant", 32'(grant0), 32'd0);
    check("rr1_addr", 32'(mem_addr0), 32'd6);
    check("rr1_busy", 32'(busy0), 32'd1);
    tick();
    check("rr1_ack_a", 32'(pa0.ack), 32'd1);
    check("rr1_ack_b", 32'(pb0.ack), 32'd0);
    check("rr1_rdata_a", 32'(pa0.rdata), 32'o0003);
    tick();
    check("rr_idle_busy", 32'(busy0), 32'd0);
    tick();
    check("rr2_grant", 32'(grant0), 32'd1);
    check("rr2_addr", 32'(mem_addr0), 32'd7);
    tick();
    check("rr2_ack_b", 32'(pb0.ack), 32'd1);
    check("rr2_ack_a", 32'(pa0.ack), 32'd0);
    check("rr2_rdata_b", 32'(pb0.rdata), 32'o0001);
    pb0.req = 0;
    tick();
    tick();
    check("rr3_grant", 32'(grant0), 32'd0);
    tick();
    check("rr3_ack_a", 32'(pa0.ack), 32'd1);
    pa0.req = 0;
    tick();

    // Reset lands in the ACCESS cycle of a B write
    ab0 = ackb_cnt0;
    pb0.req = 1; pb0.wr = 1; pb0.addr = 9'd8; pb0.wdata = 12'o0100;
    tick();
    check("rsta_wr", 32'(mem_wr0), 32'd1);
    check("rsta_addr", 32'(mem_addr0), 32'd8);
    rst0 = 1'b1;
    pb0.req = 0;
    tick();
    rst0 = 1'b0;
    check_reset0("rsta");
    check("rsta_mem", 32'(mem0[8]), 32'o0100);
    tick();
    tick();
    check("rsta_no_ack_b", 32'(ackb_cnt0 - ab0), 32'd0);

    // Back-to-back A reads with req kept up through DONE
    poke(0, 9'd1, 12'o0011);
    poke(0, 9'd2, 12'o0022);
    pa0.req = 1; pa0.wr = 0; pa0.addr = 9'd1;
    for (int k = 0; k < 3; k++) begin
      got = 0;
      for (int i = 1; i <= 6; i++) begin
        tick();
        if (pa0.ack === 1'b1) begin
          got = 1;
          break;
        end
        check("b2b_busy_access", 32'(busy0), 32'd1);
      end
      check("b2b_ack_seen", 32'(got), 32'd1);
      t[k] = cyc0;
      rd[k] = pa0.rdata;
      if (k < 2) pa0.addr = 9'(k + 2);
      else pa0.req = 0;
      tick();
      check("b2b_busy_idle", 32'(busy0), 32'd0);
    end
    check("b2b_gap1", 32'(t[1] - t[0]), 32'd3);
    check("b2b_gap2", 32'(t[2] - t[1]), 32'd3);
    check("b2b_rd1", 32'(rd[0]), 32'o0011);
    check("b2b_rd2", 32'(rd[1]), 32'o0022);
    check("b2b_rd3", 32'(rd[2]), 32'o7000);

    // Fixed priority: B waits until A lets go
    poke(1, 9'd6, 12'o0003);
    poke(1, 9'd7, 12'o0001);
    pa1.req = 1; pa1.wr = 0; pa1.addr = 9'd6;
    pb1.req = 1; pb1.wr = 0; pb1.addr = 9'd7;
    na = 0;
    nb = 0;
    for (int i = 1; i <= 9; i++) begin
      tick();
      if (pa1.ack) na++;
      if (pb1.ack) nb++;
    end
    check("fp_acks_a", 32'(na), 32'd3);
    check("fp_acks_b", 32'(nb), 32'd0);
    check("fp_rdata_a", 32'(pa1.rdata), 32'o0003);
    pa1.req = 0;
    got = 0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      if (pb1.ack === 1'b1) begin
        got = i;
        break;
      end
    end
    check("fp_b_latency", 32'(got), 32'd2);
    check("fp_rdata_b", 32'(pb1.rdata), 32'o0001);
    check("fp_grant", 32'(grant1), 32'd1);
    pb1.req = 0;
    tick();
    check("fp_ack_b_cleared", 32'(pb1.ack), 32'd0);

    check("acks_exclusive", 32'(both_ack), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
